// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request (operands/opcode) and response (result/flags) handshake
// bundle for alu_pipe. The slave side is the ALU; the master side is the
// register-file read / writeback pair around it.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             compare;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, opcode, data_in1, data_in2, out_ready,
    input  in_ready, out_valid, result, compare, flags, busy
  );

  modport slave (
    input  in_valid, opcode, data_in1, data_in2, out_ready,
    output in_ready, out_valid, result, compare, flags, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready in and out, compare bit and
// {Z,N,C,V} flags. Single-cycle ops land in the output register on the
// accepting edge. Build option ALU_MUL_EN adds an iterative shift-add
// multiplier (opcode 1011) driven by an IDLE/MUL/DONE FSM; without it 1011
// falls into the default (zero) case and busy is tied low.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;
  localparam logic [3:0] OP_BNE = 4'b1000;
  localparam logic [3:0] OP_LDA = 4'b1001;
  localparam logic [3:0] OP_STA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             compare;
    logic [3:0]       flags;   // {Z,N,C,V}
  } res_t;

  function automatic res_t mk_res(input logic [WIDTH-1:0] r, input logic cmp,
                                  input logic c, input logic v);
    res_t o;
    o.result  = r;
    o.compare = cmp;
    o.flags   = {(r == '0), r[WIDTH-1], c, v};
    return o;
  endfunction

  logic [WIDTH-1:0] a, b;
  assign a = bus.data_in1;
  assign b = bus.data_in2;

  // Output slot is free when empty or being drained this cycle.
  logic slot_free;
  logic idle;
  logic accept;
  logic is_mul;
  logic mul_load;
  logic [2*WIDTH-1:0] mul_prod;

  res_t res_q, res_d;
  logic out_valid_q, out_valid_d;

  assign slot_free    = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = idle & slot_free;
  assign accept       = bus.in_valid & bus.in_ready;

  // Single-cycle datapath; shift amounts at or above WIDTH flush to zero
  // rather than wrapping.
  logic [WIDTH-1:0] alu_r;
  logic             alu_cmp, alu_c, alu_v;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic             shift_big;

  always_comb begin
    alu_r     = '0;
    alu_cmp   = 1'b0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    sum_ext   = {1'b0, a} + {1'b0, b};
    dif_ext   = {1'b0, a} - {1'b0, b};
    shift_big = (b >= WIDTH'(WIDTH));
    unique case (bus.opcode)
      OP_ADD, OP_LDA, OP_STA: begin
        alu_r = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = dif_ext[WIDTH-1:0];
        alu_c = dif_ext[WIDTH];   // borrow: A < B unsigned
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SRL: alu_r = shift_big ? '0 : (a >> b[SHW-1:0]);
      OP_SLL: alu_r = shift_big ? '0 : (a << b[SHW-1:0]);
      OP_BEQ: alu_cmp = (a == b);
      OP_BNE: alu_cmp = (a != b);
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign idle     = (state_q == S_IDLE);
  assign bus.busy = (state_q != S_IDLE);
  assign is_mul   = (bus.opcode == OP_MUL);

  // Multiplier FSM: one partial product per MUL cycle. The last iteration
  // writes the output directly when the slot is free, so the result lands
  // WIDTH clocks after the accepting edge; otherwise park in DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_load = 1'b0;
    mul_prod = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d  = S_MUL;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_MUL: begin
        mul_prod = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = mul_prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (slot_free) begin
            mul_load = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (slot_free) begin
          mul_load = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier state; reset drops any product in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign idle     = 1'b1;
  assign bus.busy = 1'b0;
  assign is_mul   = 1'b0;
  assign mul_load = 1'b0;
  assign mul_prod = '0;
`endif

  // Output slot: drain on out_ready, refill from the ALU or the multiplier;
  // drain and refill in the same cycle leaves no bubble.
  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (accept && !is_mul) begin
      res_d       = mk_res(alu_r, alu_cmp, alu_c, alu_v);
      out_valid_d = 1'b1;
    end else if (mul_load) begin
      res_d       = mk_res(mul_prod[WIDTH-1:0], 1'b0, |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
      out_valid_d = 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q.result;
  assign bus.compare   = res_q.compare;
  assign bus.flags     = res_q.flags;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an integer
// arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int r;
    int cmp;
    int f;
  } exp_t;

  // Reference: plain integer arithmetic on the opcode table.
  function automatic exp_t model(input int op, input int ua, input int ub);
    exp_t e;
    int sa, sb, s, c, v, p;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    e.r = 0; e.cmp = 0; c = 0; v = 0;
    case (op)
      0, 9, 10: begin
        s = ua + ub; e.r = s % 256; c = (s > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      1: begin
        e.r = (ua - ub + 256) % 256; c = (ua < ub);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      2: e.r = ua & ub;
      3: e.r = ua | ub;
      4: e.r = ua ^ ub;
      5: e.r = (ub >= W) ? 0 : ua / (1 << ub);
      6: e.r = (ub >= W) ? 0 : (ua * (1 << ub)) % 256;
      7: e.cmp = (ua == ub);
      8: e.cmp = (ua != ub);
      11: if (MUL_EN) begin
        p = ua * ub; e.r = p % 256; c = (p > 255);
      end
      default: ;
    endcase
    e.f = ((e.r == 0) ? 8 : 0) + ((e.r >= 128) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op with out_ready=1, wait for its result, check it, drain it.
  task automatic run_op(input int op, input int a, input int b, input string tag);
    exp_t e;
    int dly, bcnt, rdy_while_busy;
    e = model(op, a, b);
    bus.opcode = 4'(op); bus.data_in1 = 8'(a); bus.data_in2 = 8'(b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    chk({tag, ":in_ready"}, int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    // dly = clock edges after the accepting edge until out_valid is seen
    dly = 0; bcnt = 0; rdy_while_busy = 0;
    while (!bus.out_valid && dly < 40) begin
      if (bus.busy) bcnt++;
      if (bus.in_ready) rdy_while_busy++;
      tick();
      dly++;
    end
    chk({tag, ":delay"}, dly, (MUL_EN && op == 11) ? W : 0);
    if (op == 11) begin
      chk({tag, ":busy_cycles"}, bcnt, MUL_EN ? W : 0);
      chk({tag, ":in_ready_busy"}, rdy_while_busy, 0);
    end
    chk({tag, ":result"},  int'(bus.result),  e.r);
    chk({tag, ":compare"}, int'(bus.compare), e.cmp);
    chk({tag, ":flags"},   int'(bus.flags),   e.f);
    tick();
    chk({tag, ":drained"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    exp_t e;
    int seen, op, a, b;
    bus.in_valid = 1'b0; bus.opcode = '0; bus.data_in1 = '0; bus.data_in2 = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst:out_valid", int'(bus.out_valid), 0);
    chk("rst:result",    int'(bus.result), 0);
    chk("rst:compare",   int'(bus.compare), 0);
    chk("rst:flags",     int'(bus.flags), 0);
    chk("rst:busy",      int'(bus.busy), 0);
    rst_n = 1'b1;
    tick();
    chk("rst:in_ready", int'(bus.in_ready), 1);

    // Directed boundary cases
    run_op(0,  8'hFF, 8'h01, "add_wrap");
    run_op(0,  8'h7F, 8'h01, "add_ovf");
    run_op(1,  8'h03, 8'h05, "sub_borrow");
    run_op(1,  8'h80, 8'h01, "sub_ovf");
    run_op(5,  8'h80, 9,     "srl_big");
    run_op(5,  8'h80, 8,     "srl_eq_w");
    run_op(6,  8'h01, 7,     "sll_7");
    run_op(7,  8'h2A, 8'h2A, "beq_eq");
    run_op(8,  8'h2A, 8'h2A, "bne_eq");
    run_op(9,  8'h10, 8'h20, "lda");
    run_op(10, 8'hF0, 8'h20, "sta");
    run_op(13, 8'h55, 8'hAA, "undef_op");
    run_op(11, 8'h0C, 8'h0B, "mul_0c_0b");
    run_op(11, 8'h10, 8'h10, "mul_10_10");

    // Back-to-back: one op per cycle while out_ready=1
    bus.opcode = 4'(0); bus.data_in1 = 8'h11; bus.data_in2 = 8'h22; bus.in_valid = 1'b1;
    tick();
    chk("b2b:first", int'(bus.result), 8'h33);
    chk("b2b:in_ready", int'(bus.in_ready), 1);
    bus.opcode = 4'(4); bus.data_in1 = 8'hF0; bus.data_in2 = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b:second", int'(bus.result), 8'hCC);
    chk("b2b:second_valid", int'(bus.out_valid), 1);
    tick();

    // Output stall with a second op queued behind it
    bus.out_ready = 1'b0;
    bus.opcode = 4'(0); bus.data_in1 = 8'h10; bus.data_in2 = 8'h20; bus.in_valid = 1'b1;
    tick();
    bus.opcode = 4'(1); bus.data_in1 = 8'h50; bus.data_in2 = 8'h10;
    for (int i = 0; i < 3; i++) begin
      chk("stall:out_valid", int'(bus.out_valid), 1);
      chk("stall:result", int'(bus.result), 8'h30);
      chk("stall:in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall:release_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("stall:next_result", int'(bus.result), 8'h40);
    chk("stall:next_valid", int'(bus.out_valid), 1);
    tick();
    chk("stall:no_dup", int'(bus.out_valid), 0);

    // Async reset while a result is held
    bus.out_ready = 1'b0;
    bus.opcode = 4'(0); bus.data_in1 = 8'h01; bus.data_in2 = 8'h02; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("midrst:held", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:out_valid", int'(bus.out_valid), 0);
    chk("midrst:result", int'(bus.result), 0);
    chk("midrst:flags", int'(bus.flags), 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("midrst:in_ready", int'(bus.in_ready), 1);

`ifdef ALU_MUL_EN
    // Reset pulse mid-multiply: no result may ever emerge
    bus.opcode = 4'(11); bus.data_in1 = 8'h0C; bus.data_in2 = 8'h0B; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mulrst:busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mulrst:busy_after", int'(bus.busy), 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("mulrst:no_output", seen, 0);
`endif

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = (op == 5 || op == 6) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      if (op == 7 && $urandom_range(0, 1) == 1) b = a;
      run_op(op, a, b, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
